// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad entry sequencer: FSM state codes, special
// key codes and small helpers used at elaboration and in the datapath.
package keypad_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle    = 3'd0;
  localparam state_t StEntry   = 3'd1;
  localparam state_t StSettle  = 3'd2;
  localparam state_t StRelease = 3'd3;
  localparam state_t StDone    = 3'd4;

  localparam logic [3:0] KEY_CLEAR   = 4'hE;
  localparam logic [3:0] KEY_ENTER   = 4'hF;
  localparam logic [3:0] KEY_DEC_MAX = 4'h9;

  function automatic longint unsigned ipow(input int unsigned base, input int unsigned exp);
    longint unsigned r;
    r = 64'd1;
    for (int unsigned i = 0; i < exp; i++) begin
      r = r * longint'(base);
    end
    return r;
  endfunction

  // In hex mode 0xA-0xD become digits; 0xE/0xF stay CLEAR/ENTER.
  function automatic logic is_digit(input logic [3:0] code, input logic hex_en);
    return hex_en ? (code <= 4'hD) : (code <= KEY_DEC_MAX);
  endfunction

endpackage

// File: rtl/keypad_input_ctrl_if.sv
// CPU-side request/result handshake of the keypad entry sequencer.
interface keypad_input_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  logic              req_i;
  logic              ack_i;
  logic              busy_o;
  logic              valid_o;
  logic [DATA_W-1:0] data_o;
  logic [DATA_W-1:0] entry_o;
  logic [2:0]        digits_o;

  modport master (
    output req_i,
    output ack_i,
    input  busy_o,
    input  valid_o,
    input  data_o,
    input  entry_o,
    input  digits_o
  );

  modport slave (
    input  req_i,
    input  ack_i,
    output busy_o,
    output valid_o,
    output data_o,
    output entry_o,
    output digits_o
  );
endinterface

// File: rtl/key_event_sync.sv
// Synchronises the scanner word, detects press edges and times the settle
// window after which the key code is trusted.
module key_event_sync #(
  parameter int unsigned SETTLE_CYC = 300000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] key_i,
  input  logic       arm_i,
  output logic       event_pulse,
  output logic       code_valid,
  output logic       released,
  output logic [3:0] code
);

  localparam int unsigned CntW = $clog2(SETTLE_CYC + 1);

  logic [4:0]      sync1_q, sync2_q;
  logic            flag_q;
  logic            run_q;
  logic            code_valid_q;
  logic [CntW-1:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      flag_q       <= 1'b0;
      run_q        <= 1'b0;
      code_valid_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= key_i;
      sync2_q      <= sync1_q;
      flag_q       <= sync2_q[4];
      code_valid_q <= 1'b0;
      if (arm_i && event_pulse) begin
        cnt_q <= CntW'(SETTLE_CYC);
        run_q <= 1'b1;
      end else if (run_q) begin
        cnt_q <= cnt_q - 1'b1;
        // Fire one cycle early so the code is applied SETTLE_CYC+1 after detection.
        if (cnt_q == CntW'(1)) begin
          run_q        <= 1'b0;
          code_valid_q <= 1'b1;
        end
      end
    end
  end

  assign event_pulse = sync2_q[4] & ~flag_q;
  assign released    = ~sync2_q[4];
  assign code        = sync2_q[3:0];
  assign code_valid  = code_valid_q;

endmodule

// File: rtl/keypad_input_ctrl.sv
// Keypad number-entry sequencer: FSM, accumulator and registered CPU outputs.
// Define KEYPAD_HEX_EN to accept 0x0-0xD as hex digits instead of decimal.
module keypad_input_ctrl
  import keypad_pkg::*;
#(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MAX_DIGITS = 4,
  parameter int unsigned SETTLE_CYC = 300000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4:0]          key_i,
  keypad_input_ctrl_if.slave  cpu
);

`ifdef KEYPAD_HEX_EN
  localparam logic        HexEn = 1'b1;
  localparam int unsigned Radix = 16;
`else
  localparam logic        HexEn = 1'b0;
  localparam int unsigned Radix = 10;
`endif

  localparam longint unsigned DigitSpan = ipow(Radix, MAX_DIGITS);

  if (DigitSpan > (64'd1 << DATA_W) || MAX_DIGITS > 7 || MAX_DIGITS == 0 || SETTLE_CYC == 0)
  begin : g_bad_cfg
    $error("keypad_input_ctrl: MAX_DIGITS/DATA_W/SETTLE_CYC out of range");
  end

  state_t            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d, acc_shift;
  logic [DATA_W-1:0] data_q, data_d;
  logic [2:0]        digits_q, digits_d;
  logic              busy_q, busy_d;
  logic              valid_q, valid_d;

  logic       event_pulse, code_valid, released;
  logic [3:0] code;

  key_event_sync #(
    .SETTLE_CYC (SETTLE_CYC)
  ) u_sync (
    .clk         (clk),
    .rst         (rst),
    .key_i       (key_i),
    .arm_i       (state_q == StEntry),
    .event_pulse (event_pulse),
    .code_valid  (code_valid),
    .released    (released),
    .code        (code)
  );

`ifdef KEYPAD_HEX_EN
  assign acc_shift = (acc_q << 4) | DATA_W'(code);
`else
  assign acc_shift = (acc_q << 3) + (acc_q << 1) + DATA_W'(code);
`endif

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    digits_d = digits_q;
    data_d   = data_q;
    case (state_q)
      StIdle: begin
        if (cpu.req_i) begin
          state_d  = StEntry;
          acc_d    = '0;
          digits_d = '0;
        end
      end
      StEntry: begin
        if (event_pulse) state_d = StSettle;
      end
      StSettle: begin
        if (code_valid) begin
          state_d = StRelease;
          if (code == KEY_CLEAR) begin
            acc_d    = '0;
            digits_d = '0;
          end else if (code == KEY_ENTER) begin
            if (digits_q != 3'd0) begin
              state_d = StDone;
              data_d  = acc_q;
            end
          end else if (is_digit(code, HexEn) && digits_q < 3'(MAX_DIGITS)) begin
            acc_d    = acc_shift;
            digits_d = digits_q + 3'd1;
          end
        end
      end
      StRelease: begin
        if (released) state_d = StEntry;
      end
      StDone: begin
        if (cpu.ack_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign busy_d  = (state_d == StEntry) || (state_d == StSettle) || (state_d == StRelease);
  assign valid_d = (state_d == StDone);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      digits_q <= '0;
      data_q   <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      digits_q <= digits_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
    end
  end

  assign cpu.busy_o   = busy_q;
  assign cpu.valid_o  = valid_q;
  assign cpu.data_o   = data_q;
  assign cpu.entry_o  = acc_q;
  assign cpu.digits_o = digits_q;

endmodule

// File: tb/tb_keypad_input_ctrl.sv
// Bench for keypad_input_ctrl: directed scenarios plus random sessions, checked
// every cycle against a transaction-level model of the entry rules.
module tb_keypad_input_ctrl;

  localparam int unsigned DATA_W     = 16;
  localparam int unsigned MAX_DIGITS = 4;
  localparam int unsigned SETTLE_CYC = 8;
  localparam int unsigned APPLY_LAT  = 3 + SETTLE_CYC + 1;  // flag change -> code applied
  localparam int unsigned LAG        = 4;                   // scanner value lag after flag
`ifdef KEYPAD_HEX_EN
  localparam int unsigned RADIX   = 16;
  localparam int unsigned DIG_TOP = 13;
`else
  localparam int unsigned RADIX   = 10;
  localparam int unsigned DIG_TOP = 9;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] key = '0;

  always #5 clk = ~clk;

  keypad_input_ctrl_if #(.DATA_W(DATA_W)) cpu ();

  keypad_input_ctrl #(
    .DATA_W     (DATA_W),
    .MAX_DIGITS (MAX_DIGITS),
    .SETTLE_CYC (SETTLE_CYC)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .key_i (key),
    .cpu   (cpu)
  );

  // Model: mode 0 = idle, 1 = collecting, 2 = result held.
  int                mode;
  logic [DATA_W-1:0] m_acc, m_data;
  int                m_dig;
  bit                m_busy, m_valid;
  int                n_vec = 0;
  int                n_err = 0;
  bit                chk_en = 1'b0;

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    mode = 0; m_acc = '0; m_data = '0; m_dig = 0; m_busy = 0; m_valid = 0;
  endtask

  task automatic model_apply(input logic [3:0] c);
    int unsigned t;
    if (c == 4'hE) begin
      m_acc = '0; m_dig = 0;
    end else if (c == 4'hF) begin
      if (m_dig > 0) begin
        m_data = m_acc; m_valid = 1; m_busy = 0; mode = 2;
      end
    end else if (int'(c) <= int'(DIG_TOP) && m_dig < int'(MAX_DIGITS)) begin
      t = int'(m_acc) * RADIX + int'(c);
      m_acc = DATA_W'(t);
      m_dig++;
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (chk_en) begin
      check_val("busy",   32'(cpu.busy_o),   32'(m_busy));
      check_val("valid",  32'(cpu.valid_o),  32'(m_valid));
      check_val("data",   32'(cpu.data_o),   32'(m_data));
      check_val("entry",  32'(cpu.entry_o),  32'(m_acc));
      check_val("digits", 32'(cpu.digits_o), 32'(m_dig));
    end
  end

  task automatic do_req();
    @(negedge clk); cpu.req_i = 1'b1;
    @(posedge clk);
    if (mode == 0) begin
      mode = 1; m_busy = 1; m_acc = '0; m_dig = 0;
    end
    @(negedge clk); cpu.req_i = 1'b0;
  endtask

  task automatic do_ack();
    @(negedge clk); cpu.ack_i = 1'b1;
    @(posedge clk);
    if (mode == 2) begin
      mode = 0; m_valid = 0;
    end
    @(negedge clk); cpu.ack_i = 1'b0;
  endtask

  // Scanner: flag rises first, code follows LAG cycles later. abort_at > 0 resets mid-press.
  task automatic press(input logic [3:0] c, input int hold, input int abort_at);
    int total;
    bit live, aborted;
    live    = (mode == 1);
    aborted = 0;
    total   = ((hold > int'(APPLY_LAT)) ? hold : int'(APPLY_LAT)) + 6;
    @(negedge clk); key[4] = 1'b1;
    for (int i = 1; i <= total; i++) begin
      @(posedge clk);
      if (i == int'(APPLY_LAT) && live && !aborted) model_apply(c);
      @(negedge clk);
      if (!aborted) begin
        if (i == int'(LAG)) key[3:0] = c;
        if (i == hold) key[4] = 1'b0;
        if (i == abort_at) begin
          rst = 1'b1; key = '0; aborted = 1; model_reset();
        end
      end else if (i == abort_at + 2) begin
        rst = 1'b0;
      end
    end
  endtask

  task automatic press_seq(input logic [3:0] c0, input logic [3:0] c1, input logic [3:0] c2,
                           input logic [3:0] c3, input int n);
    logic [3:0] s [4];
    s[0] = c0; s[1] = c1; s[2] = c2; s[3] = c3;
    for (int i = 0; i < n; i++) press(s[i], 6, 0);
  endtask

  initial begin
    logic [3:0] c;
    int         r;
    cpu.req_i = 1'b0;
    cpu.ack_i = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle: key ignored
    press(4'h5, 6, 0);
    check_val("idle_entry", 32'(cpu.entry_o), 32'd0);

    // 1,2,3,ENTER
    do_req();
    press_seq(4'h1, 4'h2, 4'h3, 4'hF, 4);
    check_val("t123_data", 32'(cpu.data_o), 32'h007B);
    check_val("t123_valid", 32'(cpu.valid_o), 32'd1);
    check_val("t123_digits", 32'(cpu.digits_o), 32'd3);
    do_ack();
    check_val("t123_ack", 32'(cpu.valid_o), 32'd0);

    // Fifth digit dropped
    do_req();
    for (int i = 0; i < 5; i++) press(4'h9, 6, 0);
    press(4'hF, 6, 0);
    check_val("t9999_data", 32'(cpu.data_o), 32'd9999);
    do_ack();

    // CLEAR mid-entry
    do_req();
    press_seq(4'h4, 4'h7, 4'hE, 4'h8, 4);
    press(4'hF, 6, 0);
    check_val("tclr_data", 32'(cpu.data_o), 32'd8);
    do_ack();

    // ENTER with no digits, then long hold, then A
    do_req();
    press(4'hF, 6, 0);
    check_val("tenter0_valid", 32'(cpu.valid_o), 32'd0);
    check_val("tenter0_busy", 32'(cpu.busy_o), 32'd1);
    press(4'h6, 100, 0);
    check_val("thold_digits", 32'(cpu.digits_o), 32'd1);
    press(4'hA, 6, 0);
`ifdef KEYPAD_HEX_EN
    check_val("tA_entry", 32'(cpu.entry_o), 32'h006A);
`else
    check_val("tA_entry", 32'(cpu.entry_o), 32'h0006);
`endif
    press_seq(4'hE, 4'hA, 4'h3, 4'h0, 3);
`ifdef KEYPAD_HEX_EN
    check_val("tA3_entry", 32'(cpu.entry_o), 32'h00A3);
`else
    check_val("tA3_entry", 32'(cpu.entry_o), 32'h0003);
`endif
    press(4'hF, 6, 0);
    do_ack();

    // Reset during SETTLE
    do_req();
    press_seq(4'h1, 4'h2, 4'h0, 4'h0, 2);
    press(4'h3, 30, 6);
    check_val("trst_busy", 32'(cpu.busy_o), 32'd0);
    check_val("trst_entry", 32'(cpu.entry_o), 32'd0);
    check_val("trst_data", 32'(cpu.data_o), 32'd0);
    check_val("trst_digits", 32'(cpu.digits_o), 32'd0);
    do_req();
    check_val("trst_req_entry", 32'(cpu.entry_o), 32'd0);
    press_seq(4'h4, 4'hF, 4'h0, 4'h0, 2);
    check_val("trst_data4", 32'(cpu.data_o), 32'd4);
    do_ack();

    // Random sessions
    for (int it = 0; it < 300; it++) begin
      r = int'($urandom_range(0, 9));
      if (mode == 0 && r < 7) begin
        do_req();
      end else if (mode == 2 && r < 7) begin
        do_ack();
      end else if (r == 8) begin
        do_req();
      end else if (r == 9) begin
        do_ack();
      end else begin
        c = 4'($urandom_range(0, 15));
        if ($urandom_range(0, 7) == 0) c = 4'hF;
        press(c, int'($urandom_range(1, 20)), 0);
      end
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/keypad_input_ctrl.md
# keypad_input_ctrl

Sequencer sitting between the 4x4 matrix-keypad scanner and the CPU's memory-mapped input port. On a CPU request it collects a multi-digit number from successive key presses, and it supports clear and enter keys. It presents the result through a valid/ack handshake and exposes the partial entry for the seven-segment display. It owns key-event detection: it synchronises the scanner's `{pressed, value}` word and waits for the value to settle before sampling it.

## Interface
- `DATA_W`, 16: width of the assembled number.
- `MAX_DIGITS`, 4: maximum digits accepted. Must satisfy 10^MAX_DIGITS ≤ 2^DATA_W, or 16^MAX_DIGITS ≤ 2^DATA_W in hex mode.
- `SETTLE_CYC`, 300000: clk cycles from the detected press edge to value sampling. Must be ≥ 2^18 + 2, which covers the scanner's one-key_clk value lag.
- `clk`, in, 1: system clock.
- `rst`, in, 1: reset, asynchronous, active-high.
- `key_i`, in, 5: scanner output; bit 4 = pressed flag, [3:0] = key code.
- `req_i`, in, 1: single-cycle pulse from the CPU to start an entry.
- `ack_i`, in, 1: CPU has consumed `data_o`.
- `busy_o`, out, 1: entry in progress (states ENTRY/SETTLE/RELEASE).
- `valid_o`, out, 1: `data_o` holds a completed number.
- `data_o`, out, DATA_W: completed number, stable while `valid_o` = 1.
- `entry_o`, out, DATA_W: partial accumulator, for display.
- `digits_o`, out, 3: number of digits entered so far.

## Operation
- `key_i` passes through a 2-FF synchroniser. A press event is a rising edge of the synchronised bit 4.
- Key codes:
  - 0x0–0x9 are digits.
  - 0xE = CLEAR: accumulator ← 0, digits ← 0.
  - 0xF = ENTER.
  - 0xA–0xD are ignored unless hex mode is enabled (see Configuration).
- Decimal accumulate: acc ← (acc<<3)+(acc<<1)+d, truncated to DATA_W.
- A digit arriving when digits = MAX_DIGITS is ignored.
- ENTER with digits = 0 is ignored.
- States:
  - IDLE: keys ignored; `req_i` → ENTRY, clearing acc and digits.
  - ENTRY: press event → SETTLE, counter loaded.
  - SETTLE: count down SETTLE_CYC. At zero, sample key code and apply it. ENTER (with digits > 0) → DONE, latching `data_o` ← acc. Every other code → RELEASE.
  - RELEASE: wait until synchronised flag = 0 → ENTRY. One press yields exactly one event.
  - DONE: `valid_o` = 1; `ack_i` → IDLE.
- `req_i` outside IDLE is ignored. `ack_i` outside DONE is ignored.
- If the flag drops during SETTLE, the sample is still taken and the FSM goes to RELEASE, which exits on the next cycle.
- `entry_o` mirrors the accumulator in every state. In DONE it equals `data_o`.

## Timing
- Reset values: `busy_o` = 0, `valid_o` = 0, `data_o` = 0, `entry_o` = 0, `digits_o` = 0, state IDLE, synchroniser = 0.
- `busy_o` rises the cycle after `req_i`.
- Flag edge on `key_i` → ENTRY detects it 3 clk later (2 sync + edge register). Accumulator update occurs SETTLE_CYC+1 cycles after detection.
- `valid_o` rises the cycle after ENTER is sampled. `busy_o` falls in the same cycle.
- `valid_o` falls the cycle after `ack_i`. The next `req_i` is accepted one cycle after that.
- `rst` mid-operation aborts immediately; no partial value is retained.
- All outputs are registered; no combinational input-to-output paths.

## Configuration
- `KEYPAD_HEX_EN`, defined:
  - keys 0x0–0xD are digits, accumulated as acc ← (acc<<4)|d;
  - CLEAR and ENTER are unchanged;
  - the parameter check uses the hex bound.
- Undefined: decimal mode as above, and 0xA–0xD are discarded in SETTLE (the FSM still goes to RELEASE).

## Structure
- Shared package `keypad_pkg`:
  - state enum (IDLE, ENTRY, SETTLE, RELEASE, DONE);
  - key-code constants KEY_CLEAR = 4'hE and KEY_ENTER = 4'hF;
  - the decimal-digit limit 4'h9.
- Sub-module `key_event_sync`: 2-FF synchroniser, rising-edge detect and settle counter. It outputs `event_pulse`, `code_valid` (pulse after SETTLE_CYC) and `released`.
- The top level holds the FSM, the accumulator and the output registers.

## Test plan
Bench runs with SETTLE_CYC = 8 and a scanner model whose value lags its flag by 4 cycles.
- Reset then idle: press 5 without `req_i` → `busy_o`, `valid_o`, `entry_o` stay 0.
- `req_i`, press 1, 2, 3, ENTER → `valid_o` = 1, `data_o` = 123 (0x007B), `digits_o` = 3; `ack_i` → `valid_o` = 0 next cycle.
- `req_i`, press 9 ×5 (MAX_DIGITS = 4), ENTER → `data_o` = 9999; fifth digit ignored.
- `req_i`, press 4, 7, CLEAR, 8, ENTER → `data_o` = 8. ENTER immediately after `req_i` → no `valid_o`.
- Key held for 100 cycles → exactly one digit accepted. Press A: decimal → `entry_o` unchanged; KEYPAD_HEX_EN with sequence A, 3 → `entry_o` = 0x00A3.
- Assert `rst` during SETTLE after two digits → all outputs 0 next cycle; following `req_i` starts with `entry_o` = 0.
